// File: rtl/bcd_scan_driver.sv
// Scans DIGITS captured BCD digits onto a shared active-low 7-segment bus with one-hot anode enables.
// Optional leading-zero blanking is compiled in when the macro LZB_EN is defined.
module bcd_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                r,
    input  logic [4*DIGITS-1:0] d,
    input  logic                ld,
    input  logic                en,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame,
    output logic                err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [4*DIGITS-1:0] cap;
    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic                slot_end;
    logic [3:0]          cur;
    logic [DIGITS-1:0]   an_next;
    logic                blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic logic any_invalid(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign slot_end = en && (presc == PRE_LAST);

    // Capture register, error flag and scan counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cap   <= '0;
            err   <= 1'b0;
            presc <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            if (ld) begin
                cap <= d;
                err <= any_invalid(d);
            end
            frame <= slot_end && (idx == IDX_LAST);
            if (en) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Select the current digit and build its one-hot active-low enable.
    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        cur     = 4'd0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur        = cap[4*i +: 4];
                an_next[i] = 1'b0;
            end
        end
    end

`ifdef LZB_EN
    // A slot is blanked when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (cap[4*i +: 4] == 4'd0);
            if ((idx == IDX_W'(i)) && upper_zero) blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Output registers: one cycle behind idx/cap, dark while in reset.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            seg <= 7'h7F;
            an  <= '1;
        end else if (blank) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            seg <= decode(cur);
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: two instances (PRESCALE 4 and 1) share stimulus and are
// compared every cycle against a position-counting reference model.
module tb_bcd_scan_driver;

    localparam int DIGITS = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
        logic       err;
    } out_t;

    localparam out_t RST_OUT = '{seg: 7'h7F, an: 4'hF, frame: 1'b0, err: 1'b0};

    logic        clk = 1'b0;
    logic        r;
    logic [15:0] d;
    logic        ld;
    logic        en;

    logic [6:0] seg4, seg1;
    logic [3:0] an4, an1;
    logic       frame4, frame1, err4, err1;

    int n_checks = 0;
    int n_fail   = 0;

    out_t q4[$];
    out_t q1[$];

    bcd_scan_driver #(.DIGITS(DIGITS), .PRESCALE(4)) dut4 (
        .clk(clk), .r(r), .d(d), .ld(ld), .en(en),
        .seg(seg4), .an(an4), .frame(frame4), .err(err4)
    );

    bcd_scan_driver #(.DIGITS(DIGITS), .PRESCALE(1)) dut1 (
        .clk(clk), .r(r), .d(d), .ld(ld), .en(en),
        .seg(seg1), .an(an1), .frame(frame1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Display for a given count of enabled cycles: slot = (count / prescale) mod DIGITS.
    function automatic out_t show(input logic [15:0] c, input int pos, input int pre);
        out_t o;
        int slot, val;
        bit dark;
        slot = (pos / pre) % DIGITS;
        val  = int'((c >> (4 * slot)) & 16'hF);
        dark = 1'b0;
`ifdef LZB_EN
        dark = (slot > 0) && ((c >> (4 * slot)) == 16'h0);
`endif
        o       = RST_OUT;
        if (!dark) begin
            o.seg = seg_of(val);
            o.an  = ~(4'b0001 << slot);
        end
        return o;
    endfunction

    function automatic logic bad_bcd(input logic [15:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: pushes the expected post-edge outputs for each instance.
    initial begin
        logic [15:0] mcap;
        logic        merr;
        int          pos4, pos1;
        out_t        e4, e1;
        mcap = '0; merr = 1'b0; pos4 = 0; pos1 = 0;
        forever begin
            @(posedge clk);
            if (!r) begin
                mcap = '0; merr = 1'b0; pos4 = 0; pos1 = 0;
                q4.push_back(RST_OUT);
                q1.push_back(RST_OUT);
            end else begin
                e4 = show(mcap, pos4, 4);
                e1 = show(mcap, pos1, 1);
                if (ld) begin
                    mcap = d;
                    merr = bad_bcd(d);
                end
                if (en) begin
                    pos4++;
                    pos1++;
                end
                e4.frame = en && (pos4 % (4 * DIGITS) == 0);
                e1.frame = en && (pos1 % DIGITS == 0);
                e4.err   = merr;
                e1.err   = merr;
                q4.push_back(e4);
                q1.push_back(e1);
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("p4_seg",   16'(seg4),   16'(e.seg));
                check("p4_an",    16'(an4),    16'(e.an));
                check("p4_frame", 16'(frame4), 16'(e.frame));
                check("p4_err",   16'(err4),   16'(e.err));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("p1_seg",   16'(seg1),   16'(e.seg));
                check("p1_an",    16'(an1),    16'(e.an));
                check("p1_frame", 16'(frame1), 16'(e.frame));
                check("p1_err",   16'(err1),   16'(e.err));
            end
        end
    end

    task automatic load(input logic [15:0] v);
        ld = 1'b1;
        d  = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] want, input string name);
        int n;
        n = 0;
        while (an4 !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (an4 !== want) check(name, 16'(an4), 16'(want));
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (frame4 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frame4 !== 1'b1) check(name, 16'(frame4), 16'h1);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    v[4*i +: 4] = 4'd0;
                2:       v[4*i +: 4] = 4'($urandom_range(10, 15));
                default: v[4*i +: 4] = 4'($urandom_range(0, 9));
            endcase
        end
        return v;
    endfunction

    initial begin
        r = 1'b0; d = '0; ld = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        r  = 1'b1;
        en = 1'b1;

        load(16'h1234);
        repeat (40) @(negedge clk);

        wait_an(4'b1101, "wait_an_D");
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (12) @(negedge clk);

        load(16'h9A05);
        repeat (20) @(negedge clk);
        load(16'h0009);
        repeat (6) @(negedge clk);

        // Capture on the same edge that advances the PRESCALE=4 scan from digit 0 to 1.
        wait_frame("wait_frame");
        repeat (3) @(negedge clk);
        load(16'h5555);
        repeat (20) @(negedge clk);

        load(16'h0070);
        repeat (20) @(negedge clk);
        load(16'h0000);
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-scan, checked before any further clock edge.
        load(16'h1234);
        wait_an(4'b1011, "wait_an_B");
        #2 r = 1'b0;
        #1;
        check("rst_seg",   16'(seg4),   16'h7F);
        check("rst_an",    16'(an4),    16'hF);
        check("rst_frame", 16'(frame4), 16'h0);
        check("rst_err",   16'(err4),   16'h0);
        check("rst_an_p1", 16'(an1),    16'hF);
        @(negedge clk);
        @(negedge clk);
        r = 1'b1;

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 7) == 0);
            d  = rand_digits();
            @(negedge clk);
        end
        ld = 1'b0;
        en = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
